// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame checker.
// Holds the frame state encoding, parity encoding and legal parameter ranges.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_rx_frame_chk_par_calc.sv
// Expected parity bit for a received payload.
// Even parity: bit equals the XOR of the payload; odd parity: its inverse.
module uart_par_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] payload,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Reduce payload and fold in the parity type.
    always_comb begin
        par_bit = (par_typ == PAR_ODD) ? ~(^payload) : (^payload);
    end

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: validates start bit, assembles an LSB-first
// payload, checks optional parity and one or two stop bits, and flags errors.
// Optional per-error saturating counters are built when FRAME_ERR_CNT_EN is defined.
//
// Handshake: bit_vld is a one-cycle strobe qualifying sampled_bit; every strobe
// is consumed on the clock edge where it is high, and no back-pressure exists.
// data_vld is a one-cycle pulse qualifying p_data; there is no ready signal.
module uart_rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_vld,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err,
`ifdef FRAME_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]  err_cnt_strt,
    output logic [ERR_CNT_W-1:0]  err_cnt_par,
    output logic [ERR_CNT_W-1:0]  err_cnt_stp,
`endif
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DATA   = DATA;
    localparam logic [1:0] S_PARITY = PARITY;
    localparam logic [1:0] S_STOP   = STOP;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    // Reject parameter values outside the supported frame formats.
    generate
        if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
            STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
            ERR_CNT_W < 1) begin : g_bad_param
            $error("uart_rx_frame_chk: unsupported parameter value");
        end
    endgenerate

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  exp_par_bit;

    uart_par_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_par_calc (
        .payload (shreg),
        .par_typ (par_typ_q),
        .par_bit (exp_par_bit)
    );

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Frame FSM, payload shift register and registered status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            p_data      <= '0;
            data_vld    <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_vld <= 1'b0;
            if (bit_vld) begin
                case (state)
                    S_IDLE: begin
                        if (!sampled_bit) begin
                            strt_glitch <= 1'b0;
                            par_err     <= 1'b0;
                            stp_err     <= 1'b0;
                            par_en_q    <= par_en;
                            par_typ_q   <= par_typ;
                            bit_cnt     <= '0;
                            state       <= S_DATA;
                        end else begin
                            // Earlier frame errors stay visible across a glitch.
                            strt_glitch <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        par_err <= (sampled_bit != exp_par_bit);
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (!sampled_bit) begin
                            stp_err <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                            if (!par_err && !stp_err && sampled_bit) begin
                                p_data   <= shreg;
                                data_vld <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FRAME_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic strt_ev;
    logic par_ev;
    logic stp_ev;

    // Error events coincide with the edge that sets each flag for a frame;
    // the stop event counts once per frame even with two bad stop bits.
    always_comb begin
        strt_ev = bit_vld && (state == S_IDLE) && sampled_bit;
        par_ev  = bit_vld && (state == S_PARITY) && (sampled_bit != exp_par_bit);
        stp_ev  = bit_vld && (state == S_STOP) && !sampled_bit && !stp_err;
    end

    // Saturating error counters, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_strt <= '0;
            err_cnt_par  <= '0;
            err_cnt_stp  <= '0;
        end else begin
            if (strt_ev && (err_cnt_strt != '1)) err_cnt_strt <= err_cnt_strt + CNT_ONE;
            if (par_ev  && (err_cnt_par  != '1)) err_cnt_par  <= err_cnt_par  + CNT_ONE;
            if (stp_ev  && (err_cnt_stp  != '1)) err_cnt_stp  <= err_cnt_stp  + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Testbench for uart_rx_frame_chk: one instance with one stop bit, one with two.
// Build with FRAME_ERR_CNT_EN defined to include the error counters.
module tb_uart_rx_frame_chk;
    import uart_rx_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            bv [2];
    logic            sb [2];
    logic            pe [2];
    logic            pt [2];
    logic [DW-1:0]   p_data [2];
    logic            data_vld [2];
    logic            strt_glitch [2];
    logic            par_err [2];
    logic            stp_err [2];
    logic            busy [2];
    logic [1:0]      st [2];
`ifdef FRAME_ERR_CNT_EN
    logic [CW-1:0]   cnt_s [2];
    logic [CW-1:0]   cnt_p [2];
    logic [CW-1:0]   cnt_t [2];
    int              exp_cs [2];
    int              exp_cp [2];
    int              exp_ct [2];
`endif

    // ---------------- reference model state ----------------
    logic [DW-1:0]   exp_pd [2];
    logic            exp_vld [2];
    logic            exp_strt [2];
    logic            exp_par [2];
    logic            exp_stp [2];

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_frame_chk #(.DATA_WIDTH(DW), .STOP_BITS(1), .ERR_CNT_W(CW)) u_dut1 (
        .CLK(clk), .RST(rst_n), .bit_vld(bv[0]), .sampled_bit(sb[0]),
        .par_en(pe[0]), .par_typ(pt[0]), .p_data(p_data[0]), .data_vld(data_vld[0]),
        .strt_glitch(strt_glitch[0]), .par_err(par_err[0]), .stp_err(stp_err[0]),
`ifdef FRAME_ERR_CNT_EN
        .err_cnt_strt(cnt_s[0]), .err_cnt_par(cnt_p[0]), .err_cnt_stp(cnt_t[0]),
`endif
        .busy(busy[0]), .state_dbg(st[0])
    );

    uart_rx_frame_chk #(.DATA_WIDTH(DW), .STOP_BITS(2), .ERR_CNT_W(CW)) u_dut2 (
        .CLK(clk), .RST(rst_n), .bit_vld(bv[1]), .sampled_bit(sb[1]),
        .par_en(pe[1]), .par_typ(pt[1]), .p_data(p_data[1]), .data_vld(data_vld[1]),
        .strt_glitch(strt_glitch[1]), .par_err(par_err[1]), .stp_err(stp_err[1]),
`ifdef FRAME_ERR_CNT_EN
        .err_cnt_strt(cnt_s[1]), .err_cnt_par(cnt_p[1]), .err_cnt_stp(cnt_t[1]),
`endif
        .busy(busy[1]), .state_dbg(st[1])
    );

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_pd[i] = '0; exp_vld[i] = 1'b0; exp_strt[i] = 1'b0;
            exp_par[i] = 1'b0; exp_stp[i] = 1'b0;
`ifdef FRAME_ERR_CNT_EN
            exp_cs[i] = 0; exp_cp[i] = 0; exp_ct[i] = 0;
`endif
        end
    endtask

    task automatic model_glitch(input int i);
        exp_strt[i] = 1'b1;
        exp_vld[i]  = 1'b0;
`ifdef FRAME_ERR_CNT_EN
        if (exp_cs[i] < CMAX) exp_cs[i]++;
`endif
    endtask

    // A frame is judged as a whole: parity holds when the count of ones in
    // payload plus parity bit has the parity type's oddness; stops must be 1.
    task automatic model_frame(input int i, input logic [DW-1:0] d, input logic pen,
                               input logic ptyp, input logic pbit, input logic [1:0] stops);
        int nstop;
        nstop       = (i == 0) ? 1 : 2;
        exp_strt[i] = 1'b0;
        exp_par[i]  = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
        exp_stp[i]  = (nstop == 1) ? !stops[0] : (stops != 2'b11);
        exp_vld[i]  = !exp_par[i] && !exp_stp[i];
        if (exp_vld[i]) exp_pd[i] = d;
`ifdef FRAME_ERR_CNT_EN
        if (exp_par[i] && exp_cp[i] < CMAX) exp_cp[i]++;
        if (exp_stp[i] && exp_ct[i] < CMAX) exp_ct[i]++;
`endif
    endtask

    function automatic logic good_par(input logic [DW-1:0] d, input logic ptyp);
        return logic'(($countones(d) + int'(ptyp)) % 2);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the strobe edge.
    task automatic strobe(input int i, input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            sb[i] = 1'($urandom);
            @(negedge clk);
        end
        bv[i] = 1'b1;
        sb[i] = b;
        @(negedge clk);
        bv[i] = 1'b0;
        sb[i] = 1'($urandom);
    endtask

    task automatic send_frame(input int i, input logic [DW-1:0] d, input logic pen,
                              input logic ptyp, input logic pbit, input logic [1:0] stops,
                              input int maxgap);
        int nstop;
        nstop = (i == 0) ? 1 : 2;
        pe[i] = pen;
        pt[i] = ptyp;
        strobe(i, 1'b0, $urandom_range(0, maxgap));
        pe[i] = 1'($urandom);
        pt[i] = 1'($urandom);
        for (int k = 0; k < DW; k++) strobe(i, d[k], $urandom_range(0, maxgap));
        if (pen) strobe(i, pbit, $urandom_range(0, maxgap));
        for (int s = 0; s < nstop; s++) strobe(i, stops[s], $urandom_range(0, maxgap));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            bv[i] = 1'b0; sb[i] = 1'b1; pe[i] = 1'b0; pt[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (p_data[i] !== '0 || data_vld[i] !== 1'b0 || strt_glitch[i] !== 1'b0 ||
                par_err[i] !== 1'b0 || stp_err[i] !== 1'b0 || busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got pd=%0h vld=%b sg=%b pe=%b se=%b busy=%b, want all 0",
                         i, p_data[i], data_vld[i], strt_glitch[i], par_err[i], stp_err[i], busy[i]);
            end
            n_chk++;
            if (st[i] !== IDLE) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %0d want %0d", i, st[i], IDLE);
            end
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        d = 8'hA5;
        pe[0] = 1'b0;
        strobe(0, 1'b0, 0);
        n_chk++;
        if (busy[0] !== 1'b1 || st[0] !== DATA) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%b state=%0d want 1/%0d", busy[0], st[0], DATA);
        end
        for (int k = 0; k < DW; k++) strobe(0, d[k], 1);
        strobe(0, 1'b1, 1);
        model_frame(0, d, 1'b0, 1'b0, 1'b0, 2'b11);
        n_chk++;
        if (data_vld[0] !== 1'b1 || p_data[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got vld=%b pd=%0h want 1/a5", data_vld[0], p_data[0]);
        end
        n_chk++;
        if (strt_glitch[0] !== 1'b0 || par_err[0] !== 1'b0 || stp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_errs: got sg=%b pe=%b se=%b want 0", strt_glitch[0], par_err[0], stp_err[0]);
        end
        @(negedge clk);
        n_chk++;
        if (data_vld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_vld_pulse: got %b want 0", data_vld[0]);
        end
    endtask

    task automatic test_glitch();
        model_glitch(0);
        strobe(0, 1'b1, 1);
        @(negedge clk);
        n_chk++;
        if (strt_glitch[0] !== 1'b1 || busy[0] !== 1'b0 || data_vld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_flag: got sg=%b busy=%b vld=%b want 1/0/0", strt_glitch[0], busy[0], data_vld[0]);
        end
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        model_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b11);
        n_chk++;
        if (strt_glitch[0] !== 1'b0 || data_vld[0] !== 1'b1 || p_data[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL glitch_recover: got sg=%b vld=%b pd=%0h want 0/1/3c", strt_glitch[0], data_vld[0], p_data[0]);
        end
    endtask

    task automatic test_parity();
        send_frame(0, 8'h07, 1'b1, PAR_EVEN, 1'b1, 2'b11, 1);
        model_frame(0, 8'h07, 1'b1, PAR_EVEN, 1'b1, 2'b11);
        n_chk++;
        if (par_err[0] !== 1'b0 || data_vld[0] !== 1'b1 || p_data[0] !== 8'h07) begin
            n_fail++;
            $display("FAIL parity_good: got pe=%b vld=%b pd=%0h want 0/1/07", par_err[0], data_vld[0], p_data[0]);
        end
        send_frame(0, 8'h07, 1'b1, PAR_EVEN, 1'b0, 2'b11, 1);
        model_frame(0, 8'h07, 1'b1, PAR_EVEN, 1'b0, 2'b11);
        n_chk++;
        if (par_err[0] !== exp_par[0] || data_vld[0] !== exp_vld[0] || p_data[0] !== exp_pd[0]) begin
            n_fail++;
            $display("FAIL parity_bad: got pe=%b vld=%b pd=%0h want %b/%b/%0h",
                     par_err[0], data_vld[0], p_data[0], exp_par[0], exp_vld[0], exp_pd[0]);
        end
    endtask

    task automatic test_stop2();
        send_frame(1, 8'h55, 1'b1, PAR_ODD, good_par(8'h55, PAR_ODD), 2'b01, 1);
        model_frame(1, 8'h55, 1'b1, PAR_ODD, good_par(8'h55, PAR_ODD), 2'b01);
        n_chk++;
        if (stp_err[1] !== 1'b1 || par_err[1] !== 1'b0 || data_vld[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop2_bad: got se=%b pe=%b vld=%b want 1/0/0", stp_err[1], par_err[1], data_vld[1]);
        end
        send_frame(1, 8'h12, 1'b1, PAR_ODD, good_par(8'h12, PAR_ODD), 2'b11, 1);
        model_frame(1, 8'h12, 1'b1, PAR_ODD, good_par(8'h12, PAR_ODD), 2'b11);
        n_chk++;
        if (stp_err[1] !== 1'b0 || data_vld[1] !== 1'b1 || p_data[1] !== 8'h12) begin
            n_fail++;
            $display("FAIL stop2_recover: got se=%b vld=%b pd=%0h want 0/1/12", stp_err[1], data_vld[1], p_data[1]);
        end
    endtask

    task automatic test_random(input int n, input int maxgap);
        int i;
        logic [DW-1:0] d;
        logic pen, ptyp, pbit;
        logic [1:0] stops;
        for (int t = 0; t < n; t++) begin
            i = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) begin
                model_glitch(i);
                strobe(i, 1'b1, $urandom_range(0, maxgap));
            end else begin
                d     = DW'($urandom);
                pen   = 1'($urandom);
                ptyp  = 1'($urandom);
                pbit  = good_par(d, ptyp) ^ ($urandom_range(0, 3) == 0);
                stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                send_frame(i, d, pen, ptyp, pbit, stops, maxgap);
                model_frame(i, d, pen, ptyp, pbit, stops);
            end
            n_chk++;
            if (data_vld[i] !== exp_vld[i] || p_data[i] !== exp_pd[i] || busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_data[%0d] t=%0d: got vld=%b pd=%0h busy=%b want %b/%0h/0",
                         i, t, data_vld[i], p_data[i], busy[i], exp_vld[i], exp_pd[i]);
            end
            n_chk++;
            if (strt_glitch[i] !== exp_strt[i] || par_err[i] !== exp_par[i] || stp_err[i] !== exp_stp[i]) begin
                n_fail++;
                $display("FAIL rand_flags[%0d] t=%0d: got sg=%b pe=%b se=%b want %b/%b/%b", i, t,
                         strt_glitch[i], par_err[i], stp_err[i], exp_strt[i], exp_par[i], exp_stp[i]);
            end
`ifdef FRAME_ERR_CNT_EN
            n_chk++;
            if (cnt_s[i] !== CW'(exp_cs[i]) || cnt_p[i] !== CW'(exp_cp[i]) || cnt_t[i] !== CW'(exp_ct[i])) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d] t=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, t,
                         cnt_s[i], cnt_p[i], cnt_t[i], exp_cs[i], exp_cp[i], exp_ct[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic ptyp;
        for (int t = 0; t < 4; t++) begin
            d    = DW'($urandom);
            ptyp = 1'($urandom);
            send_frame(1, d, 1'b1, ptyp, good_par(d, ptyp), 2'b11, 0);
            model_frame(1, d, 1'b1, ptyp, good_par(d, ptyp), 2'b11);
            n_chk++;
            if (data_vld[1] !== 1'b1 || p_data[1] !== d || par_err[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b t=%0d: got vld=%b pd=%0h pe=%b want 1/%0h/0", t, data_vld[1], p_data[1], par_err[1], d);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b11, 0);
        model_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b11);
        d = 8'hC3;
        pe[0] = 1'b0;
        strobe(0, 1'b0, 0);
        for (int k = 0; k < 4; k++) strobe(0, d[k], 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (p_data[0] !== '0 || busy[0] !== 1'b0 || data_vld[0] !== 1'b0 ||
            strt_glitch[0] !== 1'b0 || par_err[0] !== 1'b0 || stp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got pd=%0h busy=%b vld=%b sg=%b pe=%b se=%b want all 0",
                     p_data[0], busy[0], data_vld[0], strt_glitch[0], par_err[0], stp_err[0]);
        end
`ifdef FRAME_ERR_CNT_EN
        n_chk++;
        if (cnt_s[0] !== '0 || cnt_p[0] !== '0 || cnt_t[0] !== '0 ||
            cnt_s[1] !== '0 || cnt_p[1] !== '0 || cnt_t[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d %0d/%0d/%0d want 0",
                     cnt_s[0], cnt_p[0], cnt_t[0], cnt_s[1], cnt_p[1], cnt_t[1]);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        model_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b11);
        n_chk++;
        if (data_vld[0] !== 1'b1 || p_data[0] !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_recover: got vld=%b pd=%0h want 1/ff", data_vld[0], p_data[0]);
        end
    endtask

`ifdef FRAME_ERR_CNT_EN
    task automatic test_err_cnt();
        for (int t = 0; t < 5; t++) begin
            model_glitch(0);
            strobe(0, 1'b1, 0);
        end
        n_chk++;
        if (cnt_s[0] !== 2'd3 || cnt_p[0] !== 2'd0 || cnt_t[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL err_cnt_sat: got %0d/%0d/%0d want 3/0/0", cnt_s[0], cnt_p[0], cnt_t[0]);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_stop2();
        test_random(60, 2);
        test_back_to_back();
        test_reset_mid();
`ifdef FRAME_ERR_CNT_EN
        test_err_cnt();
`endif
        test_random(30, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
